// File: rtl/alu_muldiv_seq.sv
// Multi-cycle integer execute unit: single-cycle ALU ops plus iterative signed/unsigned
// multiply (shift-add) and divide (restoring), with valid/ready on both sides.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [3:0]       ALUctrl,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] ALUout,
  output logic [WIDTH-1:0] ALUoutHi,
  output logic             branch,
  output logic             divByZero,
  output logic             illegalOp,
  output logic             busy
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, lo_q, mb_q;
  logic [SHW-1:0]   cnt_q;
  logic             is_div_q, neg_q, neg_r_q;

  logic             accept, retire;
  logic             is_mul, is_div, signed_op, a_neg, b_neg, start_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [SHW-1:0]   shamt;

  assign inReady = (state_q == StIdle) || (state_q == StDone && outReady);
  assign busy    = (state_q != StIdle);
  assign accept  = inValid && inReady && !flush;
  assign retire  = outValid && outReady;

  assign shamt      = busB[SHW-1:0];
  assign is_mul     = (ALUctrl == 4'd10) || (ALUctrl == 4'd11);
  assign is_div     = (ALUctrl == 4'd14) || (ALUctrl == 4'd15);
  assign signed_op  = (ALUctrl == 4'd10) || (ALUctrl == 4'd15);
  assign a_neg      = signed_op && busA[WIDTH-1];
  assign b_neg      = signed_op && busB[WIDTH-1];
  assign a_mag      = a_neg ? -busA : busA;
  assign b_mag      = b_neg ? -busB : busB;
  assign start_iter = is_mul || (is_div && DIV_EN && (busB != '0));

  // Single-cycle results; also covers divide-by-zero and illegal divide.
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_br, res_dz, res_ill;

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_br  = 1'b0;
    res_dz  = 1'b0;
    res_ill = 1'b0;
    case (ALUctrl)
      4'd0:  res_lo = busA + busB;
      4'd1:  res_lo = busA - busB;
      4'd2:  res_lo = busA & busB;
      4'd3:  res_lo = busA | busB;
      4'd4:  res_lo = busA ^ busB;
      4'd5:  res_lo = busA << shamt;
      4'd6:  res_lo = busA >> shamt;
      4'd7:  res_lo = $signed(busA) >>> shamt;
      4'd8:  res_lo = {{(WIDTH-1){1'b0}}, $signed(busA) < $signed(busB)};
      4'd9:  res_lo = {{(WIDTH-1){1'b0}}, busA < busB};
      4'd12: begin
        res_br = (busA == busB);
        res_lo = {{(WIDTH-1){1'b0}}, res_br};
      end
      4'd13: begin
        res_br = (busA != busB);
        res_lo = {{(WIDTH-1){1'b0}}, res_br};
      end
      4'd14, 4'd15: begin
        if (!DIV_EN) begin
          res_ill = 1'b1;
        end else begin
          res_dz = 1'b1;
          res_lo = '1;
          res_hi = busA;
        end
      end
      default: ;
    endcase
  end

  // One radix-2 step: acc/lo hold product high/low for MUL, remainder/quotient for DIV.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   step_acc, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mb_q};
    if (is_div_q) begin
      step_acc = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], !div_diff[WIDTH]};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod     = {acc_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_r_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      lo_q      <= '0;
      mb_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      outValid  <= 1'b0;
      ALUout    <= '0;
      ALUoutHi  <= '0;
      branch    <= 1'b0;
      divByZero <= 1'b0;
      illegalOp <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      outValid  <= 1'b0;
      branch    <= 1'b0;
      divByZero <= 1'b0;
      illegalOp <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (start_iter) begin
              state_q   <= StIter;
              acc_q     <= '0;
              lo_q      <= is_div ? a_mag : b_mag;
              mb_q      <= is_div ? b_mag : a_mag;
              cnt_q     <= SHW'(WIDTH - 1);
              is_div_q  <= is_div;
              neg_q     <= a_neg ^ b_neg;
              neg_r_q   <= a_neg;
              outValid  <= 1'b0;
              branch    <= 1'b0;
              divByZero <= 1'b0;
              illegalOp <= 1'b0;
            end else begin
              state_q   <= StDone;
              outValid  <= 1'b1;
              ALUout    <= res_lo;
              ALUoutHi  <= res_hi;
              branch    <= res_br;
              divByZero <= res_dz;
              illegalOp <= res_ill;
            end
          end else if (retire) begin
            state_q   <= StIdle;
            outValid  <= 1'b0;
            branch    <= 1'b0;
            divByZero <= 1'b0;
            illegalOp <= 1'b0;
          end
        end
        StIter: begin
          acc_q <= step_acc;
          lo_q  <= step_lo;
          if (cnt_q == '0) state_q <= StFix;
          else cnt_q <= cnt_q - SHW'(1);
        end
        StFix: begin
          if (is_div_q) begin
            ALUout   <= quo_fix;
            ALUoutHi <= rem_fix;
          end else begin
            {ALUoutHi, ALUout} <= prod_fix;
          end
          outValid <= 1'b1;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
